// File: rtl/ad_input_ctrl_if.sv
// Player-input bus for ad_input_ctrl: PS/2 key event word, joystick word and the
// active-low button bus presented to the game core.
interface ad_input_ctrl_if;
  logic [10:0] ps2_key;
  logic [15:0] joy;
  logic [7:0]  button_n;

  modport master (output ps2_key, output joy, input button_n);
  modport slave  (input ps2_key, input joy, output button_n);
endinterface

// File: rtl/ad_input_ctrl.sv
// Asteroids Deluxe player-input front end. Decodes toggle-framed PS/2 key events
// into per-key latches, ORs them with the registered joystick, cancels opposing
// rotation and stretches coin presses to a minimum width.
// Optional feature: define AD_AUTOFIRE_EN to make held fire pulse with a half-period
// of AUTOFIRE_PERIOD cycles.
module ad_input_ctrl #(
  parameter int unsigned COIN_HOLD_CYCLES = 2500000,
  parameter int unsigned AUTOFIRE_PERIOD  = 1250000
) (
  input  logic           clk_25,
  input  logic           RESET_L,
  ad_input_ctrl_if.slave bus
);

  localparam logic [21:0] CoinLoad = 22'(COIN_HOLD_CYCLES - 1);

  // Key latch indices
  localparam logic [4:0] KeyM     = 5'd0;
  localparam logic [4:0] KeyF1    = 5'd1;
  localparam logic [4:0] KeyF2    = 5'd2;
  localparam logic [4:0] KeyA     = 5'd3;
  localparam logic [4:0] KeyD     = 5'd4;
  localparam logic [4:0] KeyF3    = 5'd5;
  localparam logic [4:0] KeyL     = 5'd6;
  localparam logic [4:0] KeyK     = 5'd7;
  localparam logic [4:0] KeySpace = 5'd8;
  localparam logic [4:0] Key1     = 5'd9;
  localparam logic [4:0] Key2     = 5'd10;
  localparam logic [4:0] Key5     = 5'd11;
  localparam logic [4:0] Key6     = 5'd12;
  localparam logic [4:0] KeyLeft  = 5'd13;
  localparam logic [4:0] KeyRight = 5'd14;
  localparam logic [4:0] KeyCtrl  = 5'd15;
  localparam logic [4:0] KeyAlt   = 5'd16;

  typedef enum logic [1:0] {StIdle, StHold, StWaitRel} coin_state_e;

  logic        tog_q, armed_q;
  logic [16:0] key_q, key_d;
  logic [8:0]  joy_q;
  logic        ps2_event;
  logic        key_hit;
  logic [4:0]  key_idx;

  logic fire_f, thrust_f, shield_f, left_raw, right_raw, left_f, right_f;
  logic start1_f, start2_f, coin_src, coin_rise, fire_out;

  coin_state_e coin_state_q;
  logic [21:0] coin_cnt_q;
  logic        coin_src_q, coin_q;
  logic [4:0]  hi_n_q;
  logic [1:0]  lo_n_q;

  logic unused_joy;
  assign unused_joy = ^{bus.joy[15:9], bus.joy[3:2]};

  assign ps2_event = armed_q & (bus.ps2_key[10] ^ tog_q);

  // Scancode decode and latch next-state; arrows, ctrl and alt ignore the extended flag
  always_comb begin
    key_hit = 1'b0;
    key_idx = KeyM;
    case (bus.ps2_key[7:0])
      8'h3A: begin key_hit = ~bus.ps2_key[8]; key_idx = KeyM;     end
      8'h05: begin key_hit = ~bus.ps2_key[8]; key_idx = KeyF1;    end
      8'h06: begin key_hit = ~bus.ps2_key[8]; key_idx = KeyF2;    end
      8'h1C: begin key_hit = ~bus.ps2_key[8]; key_idx = KeyA;     end
      8'h23: begin key_hit = ~bus.ps2_key[8]; key_idx = KeyD;     end
      8'h04: begin key_hit = ~bus.ps2_key[8]; key_idx = KeyF3;    end
      8'h4B: begin key_hit = ~bus.ps2_key[8]; key_idx = KeyL;     end
      8'h42: begin key_hit = ~bus.ps2_key[8]; key_idx = KeyK;     end
      8'h29: begin key_hit = ~bus.ps2_key[8]; key_idx = KeySpace; end
      8'h16: begin key_hit = ~bus.ps2_key[8]; key_idx = Key1;     end
      8'h1E: begin key_hit = ~bus.ps2_key[8]; key_idx = Key2;     end
      8'h2E: begin key_hit = ~bus.ps2_key[8]; key_idx = Key5;     end
      8'h36: begin key_hit = ~bus.ps2_key[8]; key_idx = Key6;     end
      8'h6B: begin key_hit = 1'b1;            key_idx = KeyLeft;  end
      8'h74: begin key_hit = 1'b1;            key_idx = KeyRight; end
      8'h14: begin key_hit = 1'b1;            key_idx = KeyCtrl;  end
      8'h11: begin key_hit = 1'b1;            key_idx = KeyAlt;   end
      default: ;
    endcase
    key_d = key_q;
    if (ps2_event && key_hit) key_d[key_idx] = bus.ps2_key[9];
  end

  // Input stage: toggle history, arm flag, key latches, joystick register
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      tog_q   <= 1'b0;
      armed_q <= 1'b0;
      key_q   <= '0;
      joy_q   <= '0;
    end else begin
      tog_q   <= bus.ps2_key[10];
      armed_q <= 1'b1;
      key_q   <= key_d;
      joy_q   <= bus.joy[8:0];
    end
  end

  assign fire_f    = key_q[KeyM]  | key_q[KeyCtrl]  | joy_q[4];
  assign thrust_f  = key_q[KeyL]  | key_q[KeyAlt]   | joy_q[5];
  assign shield_f  = key_q[KeyK]  | key_q[KeySpace] | joy_q[6];
  assign left_raw  = key_q[KeyA]  | key_q[KeyLeft]  | joy_q[1];
  assign right_raw = key_q[KeyD]  | key_q[KeyRight] | joy_q[0];
  assign start1_f  = key_q[KeyF1] | key_q[Key1]     | joy_q[7];
  assign start2_f  = key_q[KeyF2] | key_q[Key2];
  assign coin_src  = key_q[KeyF3] | key_q[Key5] | key_q[Key6] | joy_q[8];
  assign coin_rise = coin_src & ~coin_src_q;

  // Both directions at once means neither
  assign left_f  = left_raw & ~right_raw;
  assign right_f = right_raw & ~left_raw;

  // Coin stretcher FSM; coin_q is its registered output bit
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      coin_state_q <= StIdle;
      coin_cnt_q   <= '0;
      coin_src_q   <= 1'b0;
      coin_q       <= 1'b0;
    end else begin
      coin_src_q <= coin_src;
      unique case (coin_state_q)
        StIdle: begin
          if (coin_rise) begin
            coin_cnt_q   <= CoinLoad;
            coin_state_q <= StHold;
            coin_q       <= 1'b1;
          end
        end
        StHold: begin
          if (coin_cnt_q == '0) begin
            coin_state_q <= coin_src ? StWaitRel : StIdle;
            coin_q       <= coin_src;
          end else begin
            coin_cnt_q <= coin_cnt_q - 22'd1;
          end
        end
        StWaitRel: begin
          if (!coin_src) begin
            coin_state_q <= StIdle;
            coin_q       <= 1'b0;
          end
        end
        default: begin
          coin_state_q <= StIdle;
          coin_q       <= 1'b0;
        end
      endcase
    end
  end

`ifdef AD_AUTOFIRE_EN
  localparam logic [21:0] AfLast = 22'(AUTOFIRE_PERIOD - 1);

  logic [21:0] af_cnt_q;
  logic        af_off_q;

  // Autofire phase: on for AUTOFIRE_PERIOD cycles, off for the same, restart on release
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      af_cnt_q <= '0;
      af_off_q <= 1'b0;
    end else if (!fire_f) begin
      af_cnt_q <= '0;
      af_off_q <= 1'b0;
    end else if (af_cnt_q == AfLast) begin
      af_cnt_q <= '0;
      af_off_q <= ~af_off_q;
    end else begin
      af_cnt_q <= af_cnt_q + 22'd1;
    end
  end

  assign fire_out = fire_f & ~af_off_q;
`else
  localparam int unsigned UnusedAfPeriod = AUTOFIRE_PERIOD;
  assign fire_out = fire_f;
`endif

  // Output register, active-low
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      hi_n_q <= '1;
      lo_n_q <= '1;
    end else begin
      hi_n_q <= ~{right_f, left_f, start1_f, start2_f, fire_out};
      lo_n_q <= ~{thrust_f, shield_f};
    end
  end

  assign bus.button_n = {hi_n_q, ~coin_q, lo_n_q};

endmodule

// File: tb/tb_ad_input_ctrl.sv
// Randomized self-checking bench for ad_input_ctrl with a cycle-level reference model.
module tb_ad_input_ctrl;
  localparam int unsigned CoinHold = 8;
  localparam int unsigned AfPeriod = 4;

  logic clk_25  = 1'b0;
  logic RESET_L = 1'b0;

  ad_input_ctrl_if bus();

  ad_input_ctrl #(
    .COIN_HOLD_CYCLES(CoinHold),
    .AUTOFIRE_PERIOD (AfPeriod)
  ) dut (
    .clk_25 (clk_25),
    .RESET_L(RESET_L),
    .bus    (bus)
  );

  always #20 clk_25 = ~clk_25;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference model state
  bit          key_down[string];
  logic [15:0] m_joy;
  bit          m_tog, m_armed, m_src_prev, m_in_session, m_fire_prev;
  int          m_k, m_start, m_fire_start;
  logic [7:0]  exp_button;

  function automatic bit kd(input string n);
    return key_down.exists(n) ? key_down[n] : 1'b0;
  endfunction

  function automatic string key_name(input bit ext, input logic [7:0] code);
    case (code)
      8'h6B: return "left";
      8'h74: return "right";
      8'h14: return "ctrl";
      8'h11: return "alt";
      default: ;
    endcase
    if (ext) return "";
    case (code)
      8'h3A: return "M";
      8'h05: return "F1";
      8'h06: return "F2";
      8'h1C: return "A";
      8'h23: return "D";
      8'h04: return "F3";
      8'h4B: return "L";
      8'h42: return "K";
      8'h29: return "space";
      8'h16: return "1";
      8'h1E: return "2";
      8'h2E: return "5";
      8'h36: return "6";
      default: return "";
    endcase
  endfunction

  function automatic void model_reset();
    key_down.delete();
    m_joy        = '0;
    m_tog        = 1'b0;
    m_armed      = 1'b0;
    m_src_prev   = 1'b0;
    m_in_session = 1'b0;
    m_fire_prev  = 1'b0;
    m_k          = 0;
    m_start      = 0;
    m_fire_start = 0;
    exp_button   = 8'hFF;
  endfunction

  // One rising edge: output reflects state held before the edge, then inputs are absorbed
  function automatic void model_edge();
    bit fire, thrust, shield, left, right, s1, s2, src, fire_o;
    string name;
    fire   = kd("M") | kd("ctrl") | m_joy[4];
    thrust = kd("L") | kd("alt") | m_joy[5];
    shield = kd("K") | kd("space") | m_joy[6];
    left   = kd("A") | kd("left") | m_joy[1];
    right  = kd("D") | kd("right") | m_joy[0];
    s1     = kd("F1") | kd("1") | m_joy[7];
    s2     = kd("F2") | kd("2");
    src    = kd("F3") | kd("5") | kd("6") | m_joy[8];
    if (left && right) begin
      left  = 1'b0;
      right = 1'b0;
    end
    // Coin: a session opens on a rising source and lasts at least CoinHold edges,
    // then closes on the first edge after that with the source low
    if (!m_in_session) begin
      if (src && !m_src_prev) begin
        m_in_session = 1'b1;
        m_start      = m_k;
      end
    end else if ((m_k - m_start) >= int'(CoinHold) && !src) begin
      m_in_session = 1'b0;
    end
    m_src_prev = src;
    if (fire && !m_fire_prev) m_fire_start = m_k;
    m_fire_prev = fire;
`ifdef AD_AUTOFIRE_EN
    fire_o = fire && ((((m_k - m_fire_start) / int'(AfPeriod)) % 2) == 0);
`else
    fire_o = fire;
`endif
    exp_button = ~{right, left, s1, s2, fire_o, m_in_session, thrust, shield};
    if (m_armed && (bus.ps2_key[10] != m_tog)) begin
      name = key_name(bus.ps2_key[8], bus.ps2_key[7:0]);
      if (name != "") key_down[name] = bus.ps2_key[9];
    end
    m_tog   = bus.ps2_key[10];
    m_armed = 1'b1;
    m_joy   = bus.joy;
    m_k++;
  endfunction

  task automatic cycle();
    @(posedge clk_25);
    if (RESET_L) model_edge();
    else exp_button = 8'hFF;
    @(negedge clk_25);
    check("button_n", bus.button_n, exp_button);
  endtask

  task automatic send_key(input bit pressed, input bit ext, input logic [7:0] code);
    bus.ps2_key = {~bus.ps2_key[10], pressed, ext, code};
    cycle();
  endtask

  int lows;
  task automatic run_count(input int n);
    repeat (n) begin
      cycle();
      if (bus.button_n[2] == 1'b0) lows++;
    end
  endtask

  logic [7:0] codes [19] = '{8'h3A, 8'h05, 8'h06, 8'h1C, 8'h23, 8'h04, 8'h4B, 8'h42, 8'h29,
                             8'h16, 8'h1E, 8'h2E, 8'h36, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h5A,
                             8'h00};
  logic [7:0] pat;

  initial begin
    bus.ps2_key = 11'h400;
    bus.joy     = '0;
    RESET_L     = 1'b0;
    model_reset();
    repeat (3) cycle();
    RESET_L = 1'b1;
    repeat (4) cycle();
    check("reset_idle", bus.button_n, 8'hFF);

    // Fire from M, with ctrl pressed and released on top
    send_key(1'b1, 1'b0, 8'h3A);
    check("m_not_yet", 32'(bus.button_n[3]), 1);
    cycle();
    check("m_fire", 32'(bus.button_n[3]), 0);
    send_key(1'b1, 1'b1, 8'h14);
    cycle();
    send_key(1'b0, 1'b1, 8'h14);
    cycle();
    check("ctrl_rel_m_held", 32'(bus.button_n[3]), 0);
    send_key(1'b0, 1'b0, 8'h3A);
    cycle();
    check("m_release", 32'(bus.button_n[3]), 1);

    // Rotation cancel
    bus.joy[1] = 1'b1;
    send_key(1'b1, 1'b0, 8'h23);
    cycle();
    check("rot_cancel", 32'(bus.button_n[7:6]), 2'b11);
    bus.joy[1] = 1'b0;
    cycle();
    cycle();
    check("rot_right", 32'(bus.button_n[7:6]), 2'b01);
    send_key(1'b0, 1'b0, 8'h23);
    cycle();

    // Coin: short pulse, long hold, retrigger mid-hold, key '5'
    lows = 0;
    bus.joy[8] = 1'b1; run_count(1);
    bus.joy[8] = 1'b0; run_count(15);
    check("coin_short", lows, CoinHold);
    lows = 0;
    bus.joy[8] = 1'b1; run_count(20);
    bus.joy[8] = 1'b0; run_count(10);
    check("coin_long", lows, 20);
    lows = 0;
    bus.joy[8] = 1'b1; run_count(1);
    bus.joy[8] = 1'b0; run_count(3);
    bus.joy[8] = 1'b1; run_count(1);
    bus.joy[8] = 1'b0; run_count(15);
    check("coin_no_retrig", lows, CoinHold);
    lows = 0;
    send_key(1'b1, 1'b0, 8'h2E);
    if (bus.button_n[2] == 1'b0) lows++;
    send_key(1'b0, 1'b0, 8'h2E);
    if (bus.button_n[2] == 1'b0) lows++;
    run_count(14);
    check("coin_key5", lows, CoinHold);

    // Asynchronous reset mid-hold with shield latched
    send_key(1'b1, 1'b0, 8'h42);
    cycle();
    check("shield_k", 32'(bus.button_n[0]), 0);
    bus.joy[8] = 1'b1; cycle();
    bus.joy[8] = 1'b0; cycle(); cycle();
    check("coin_before_rst", 32'(bus.button_n[2]), 0);
    #5 RESET_L = 1'b0;
    #1 check("async_reset", bus.button_n, 8'hFF);
    model_reset();
    cycle();
    RESET_L = 1'b1;
    cycle();
    send_key(1'b0, 1'b0, 8'h42);
    cycle();
    cycle();
    check("k_release_after_rst", bus.button_n, 8'hFF);

    // Held fire pattern
    pat = '0;
    bus.joy[4] = 1'b1;
    cycle();
    repeat (8) begin
      cycle();
      pat = {pat[6:0], bus.button_n[3]};
    end
`ifdef AD_AUTOFIRE_EN
    check("fire_pattern", pat, 8'h0F);
`else
    check("fire_pattern", pat, 8'h00);
`endif
    bus.joy[4] = 1'b0;
    cycle();
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) begin
        bus.ps2_key = {~bus.ps2_key[10], 1'($urandom_range(1)), ($urandom_range(3) == 0),
                       codes[$urandom_range(18)]};
      end
      if ($urandom_range(7) == 0) bus.joy = 16'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
